pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Controls the PLL from the other side of its rst/locked interface.
- Drives the PLL's active-high `rst` input and consumes its asynchronous `locked` output.
- Releases a system reset only after lock has been continuously stable; re-arms the PLL on lock loss or lock timeout.
- Runs on the 50 MHz board reference clock, which also feeds the PLL, so it never depends on the clock it supervises.

Parameters:
- RST_CYCLES, 16: refclk cycles `pll_rst` is held high per PLL reset attempt (>=2).
- LOCK_TIMEOUT, 50000: refclk cycles to wait for lock before re-resetting the PLL; 1 ms at 50 MHz (>=2).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before `sys_rst_n` is released (>=2).
- STAT_W, 8: width of the saturating statistics counters.

Ports:
- refclk  in  1  board reference clock (50 MHz); the only clock.
- rst_n  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to refclk upstream.
- pll_locked  in  1  PLL locked flag; asynchronous to refclk.
- clr_stats  in  1  single-cycle pulse that clears both statistics counters.
- pll_rst  out  1  active-high reset to the PLL `rst` input.
- sys_rst_n  out  1  active-low reset to the downstream logic on the PLL output clock.
- state  out  2  current FSM state: 0 RST_PLL, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN.
- lock_loss_cnt  out  STAT_W  saturating count of lock losses seen in RUN.
- timeout_cnt  out  STAT_W  saturating count of WAIT_LOCK timeouts.

Behaviour:
- One clock domain: refclk. Async active-low reset `rst_n`. All outputs are registered.
- Reset values:
  - state = RST_PLL, pll_rst = 1, sys_rst_n = 0.
  - Both statistics counters = 0, cycle counter = 0, both synchronizer flops = 0.
- Synchronizer: 2-flop chain on pll_locked produces `locked_s`. The FSM uses only `locked_s`.
- Cycle counter: one shared counter, sized ceil(log2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))). It is zeroed on every state change.
- RST_PLL:
  - pll_rst = 1, sys_rst_n = 0.
  - When the counter reaches RST_CYCLES-1, go to WAIT_LOCK; pll_rst goes to 0 on that same edge.
  - pll_rst is therefore high for exactly RST_CYCLES cycles, counted from entry into RST_PLL.
- WAIT_LOCK:
  - If locked_s = 1, go to STABILIZE.
  - Else, when the counter reaches LOCK_TIMEOUT-1, go to RST_PLL and increment timeout_cnt.
  - If locked_s rises on the timeout cycle, lock wins and the FSM goes to STABILIZE.
- STABILIZE:
  - If locked_s = 0, go back to WAIT_LOCK with the counter zeroed; this glitch is not counted.
  - Else, when the counter reaches STABLE_CYCLES-1, go to RUN; sys_rst_n goes to 1 on that edge.
- RUN:
  - sys_rst_n = 1.
  - If locked_s = 0, go to RST_PLL; on that edge pll_rst goes to 1, sys_rst_n goes to 0, and lock_loss_cnt increments.
- Latency, pll_locked held high from WAIT_LOCK: sys_rst_n rises exactly STABLE_CYCLES+3 refclk edges after the first edge that samples pll_locked = 1.
- Latency, pll_locked falling in RUN: sys_rst_n falls and pll_rst rises on the 3rd edge after the drop is first sampled.
- Statistics counters:
  - Saturate at 2^STAT_W-1 and never wrap.
  - clr_stats zeroes both counters on the next edge.
  - If clr_stats coincides with an increment, the clear wins (result 0).
- Reset mid-operation: asserting rst_n in any state immediately forces reset values, i.e. pll_rst = 1, sys_rst_n = 0, and counters cleared.
- A pll_locked pulse shorter than one refclk period may be missed; this is acceptable and produces no error output.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, STAT_W=4.
- Power-up: release rst_n with pll_locked=0 -> pll_rst high for 4 cycles, then 0 with state=1; sys_rst_n stays 0.
- Normal lock: raise pll_locked 3 cycles into WAIT_LOCK and hold it -> sys_rst_n=1 exactly 11 edges after the first sample; state=3; both counters 0.
- Timeout: hold pll_locked=0 -> after 20 cycles in WAIT_LOCK, state=0 and pll_rst=1 for 4 cycles; timeout_cnt=1; after 17 retries timeout_cnt saturates at 15.
- Glitch during STABILIZE: drop pll_locked for 2 cycles at counter=5 -> state returns to 1, the stabilization count restarts from 0, and sys_rst_n rises 11 edges after the relock; lock_loss_cnt stays 0.
- Lock loss in RUN: drop pll_locked -> on the 3rd edge sys_rst_n=0, pll_rst=1, state=0, lock_loss_cnt=1; a pulse on clr_stats then reads 0.
- Async reset in RUN: pulse rst_n low mid-cycle -> pll_rst=1 and sys_rst_n=0 without waiting for a clock edge; the counters read 0.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// Signals between the PLL lock supervisor and the PLL/system side: lock input,
// stats clear, the two resets it generates and its status outputs.
interface pll_lock_supervisor_if #(
   parameter int STAT_W = 8
);
   logic              pll_locked;
   logic              clr_stats;
   logic              pll_rst;
   logic              sys_rst_n;
   logic [1:0]        state;
   logic [STAT_W-1:0] lock_loss_cnt;
   logic [STAT_W-1:0] timeout_cnt;

   modport master (
      output pll_locked, clr_stats,
      input  pll_rst, sys_rst_n, state, lock_loss_cnt, timeout_cnt
   );

   modport slave (
      input  pll_locked, clr_stats,
      output pll_rst, sys_rst_n, state, lock_loss_cnt, timeout_cnt
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset and system reset release from the board reference clock,
// re-arming the PLL on lock loss or lock timeout.
module pll_lock_supervisor #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int STAT_W        = 8
) (
   input  logic                  refclk,
   input  logic                  rst_n,
   pll_lock_supervisor_if.slave  bus
);

   typedef enum logic [1:0] {
      RST_PLL   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABILIZE = 2'd2,
      RUN       = 2'd3
   } state_e;

   localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CNT_W  = (MAX_C > 2) ? $clog2(MAX_C) : 1;

   localparam logic [CNT_W-1:0]  RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [STAT_W-1:0] STAT_MAX     = '1;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == STAT_MAX) ? v : v + 1'b1;
   endfunction

   logic              sync1_q, sync2_q;
   logic              locked_s;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pll_rst_q, pll_rst_d;
   logic              sys_rst_n_q, sys_rst_n_d;
   logic [STAT_W-1:0] lock_loss_q, lock_loss_d;
   logic [STAT_W-1:0] timeout_q, timeout_d;
   logic              timeout_evt, loss_evt;

   assign locked_s = sync2_q;

   // State register: everything, including the synchronizer, is cleared by rst_n.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= RST_PLL;
         cnt_q       <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         lock_loss_q <= '0;
         timeout_q   <= '0;
      end else begin
         sync1_q     <= bus.pll_locked;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         lock_loss_q <= lock_loss_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next state. Lock is checked before the timeout so a late lock still wins.
   always_comb begin
      state_d     = state_q;
      timeout_evt = 1'b0;
      loss_evt    = 1'b0;
      case (state_q)
         RST_PLL: begin
            if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_d = STABILIZE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d     = RST_PLL;
               timeout_evt = 1'b1;
            end
         end
         STABILIZE: begin
            if (!locked_s)                 state_d = WAIT_LOCK;
            else if (cnt_q == STABLE_LAST) state_d = RUN;
         end
         RUN: begin
            if (!locked_s) begin
               state_d  = RST_PLL;
               loss_evt = 1'b1;
            end
         end
         default: state_d = RST_PLL;
      endcase
   end

   // Outputs are decoded from the next state so they change on the transition edge.
   always_comb begin
      pll_rst_d   = (state_d == RST_PLL);
      sys_rst_n_d = (state_d == RUN);

      if (state_d != state_q)  cnt_d = '0;
      else if (state_q == RUN) cnt_d = cnt_q;
      else                     cnt_d = cnt_q + 1'b1;

      lock_loss_d = lock_loss_q;
      timeout_d   = timeout_q;
      if (bus.clr_stats) begin
         lock_loss_d = '0;
         timeout_d   = '0;
      end else begin
         if (loss_evt)    lock_loss_d = sat_inc(lock_loss_q);
         if (timeout_evt) timeout_d   = sat_inc(timeout_q);
      end
   end

   assign bus.pll_rst       = pll_rst_q;
   assign bus.sys_rst_n     = sys_rst_n_q;
   assign bus.state         = state_q;
   assign bus.lock_loss_cnt = lock_loss_q;
   assign bus.timeout_cnt   = timeout_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters; expected values
// go through a scoreboard queue and are compared against DUT outputs.
module tb_pll_lock_supervisor;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int STAT_W        = 4;

   localparam int S_STATE = 0;
   localparam int S_PRST  = 1;
   localparam int S_SRSTN = 2;

   logic refclk;
   logic rst_n;

   pll_lock_supervisor_if #(.STAT_W(STAT_W)) bus ();

   pll_lock_supervisor #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .STAT_W       (STAT_W)
   ) dut (
      .refclk(refclk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic push_exp(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check_out(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL sb_empty: observed %0d, expected <none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val)
         else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      push_exp(tag, exp);
      check_out(obs);
   endtask

   function automatic logic [31:0] sig(input int sel);
      case (sel)
         S_STATE: return {30'd0, bus.state};
         S_PRST:  return {31'd0, bus.pll_rst};
         default: return {31'd0, bus.sys_rst_n};
      endcase
   endfunction

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   // Ticks until the selected output equals val; the arrival itself is a check.
   task automatic wait_for(input string tag, input int sel, input logic [31:0] val,
                           input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (sig(sel) !== val && n < budget);
      chk(tag, sig(sel), val);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   int n;
   int n2;
   int exp_to;

   initial begin
      rst_n          = 1'b0;
      bus.pll_locked = 1'b0;
      bus.clr_stats  = 1'b0;
      #12;
      chk("rst_state",     {30'd0, bus.state},         0);
      chk("rst_pll_rst",   {31'd0, bus.pll_rst},       1);
      chk("rst_sys_rst_n", {31'd0, bus.sys_rst_n},     0);
      chk("rst_loss",      {28'd0, bus.lock_loss_cnt}, 0);
      chk("rst_timeout",   {28'd0, bus.timeout_cnt},   0);

      // Power-up: pll_rst high for exactly RST_CYCLES cycles
      tick();
      rst_n = 1'b1;
      for (int i = 1; i <= RST_CYCLES; i++) begin
         tick();
         chk("pwr_sys_rst_n", {31'd0, bus.sys_rst_n}, 0);
         if (i < RST_CYCLES) begin
            chk("pwr_pll_rst_hi", {31'd0, bus.pll_rst}, 1);
            chk("pwr_state_rst",  {30'd0, bus.state},   0);
         end else begin
            chk("pwr_pll_rst_lo", {31'd0, bus.pll_rst}, 0);
            chk("pwr_state_wait", {30'd0, bus.state},   1);
         end
      end

      // Normal lock, raised 3 cycles into WAIT_LOCK
      repeat (3) tick();
      bus.pll_locked = 1'b1;
      wait_for("lock_rise", S_SRSTN, 1, 40, n);
      chk("lock_latency", n, STABLE_CYCLES + 3);
      chk("lock_state",   {30'd0, bus.state},         3);
      chk("lock_pll_rst", {31'd0, bus.pll_rst},       0);
      chk("lock_loss0",   {28'd0, bus.lock_loss_cnt}, 0);
      chk("lock_to0",     {28'd0, bus.timeout_cnt},   0);

      // Lock loss in RUN, then clear
      bus.pll_locked = 1'b0;
      wait_for("loss_fall", S_SRSTN, 0, 10, n);
      chk("loss_latency", n, 3);
      chk("loss_pll_rst", {31'd0, bus.pll_rst},       1);
      chk("loss_state",   {30'd0, bus.state},         0);
      chk("loss_cnt1",    {28'd0, bus.lock_loss_cnt}, 1);
      bus.clr_stats = 1'b1;
      tick();
      bus.clr_stats = 1'b0;
      chk("clr_loss", {28'd0, bus.lock_loss_cnt}, 0);

      // Timeout and saturation of timeout_cnt
      wait_for("to_enter_wait", S_STATE, 1, 10, n);
      wait_for("to_expire", S_STATE, 0, 40, n);
      chk("to_latency", n, LOCK_TIMEOUT);
      chk("to_cnt1",    {28'd0, bus.timeout_cnt}, 1);
      chk("to_pll_rst", {31'd0, bus.pll_rst},     1);
      wait_for("to_rst_len", S_STATE, 1, 10, n);
      chk("to_rst_cycles", n, RST_CYCLES);
      chk("to_pll_rst_lo", {31'd0, bus.pll_rst}, 0);
      for (int k = 2; k <= 17; k++) begin
         wait_for("to_retry", S_STATE, 0, 40, n);
         exp_to = (k > 15) ? 15 : k;
         chk("to_sat", {28'd0, bus.timeout_cnt}, exp_to);
         wait_for("to_rewait", S_STATE, 1, 10, n);
      end

      // Glitch during STABILIZE at counter=5
      bus.pll_locked = 1'b1;
      wait_for("gl_stab", S_STATE, 2, 10, n);
      chk("gl_stab_latency", n, 3);
      repeat (5) tick();
      bus.pll_locked = 1'b0;
      tick();
      tick();
      bus.pll_locked = 1'b1;
      tick();
      chk("gl_back_wait", {30'd0, bus.state},     1);
      chk("gl_sys_rst_n", {31'd0, bus.sys_rst_n}, 0);
      wait_for("gl_rise", S_SRSTN, 1, 40, n2);
      chk("gl_relock_latency", n2 + 1, STABLE_CYCLES + 3);
      chk("gl_state_run", {30'd0, bus.state},         3);
      chk("gl_loss0",     {28'd0, bus.lock_loss_cnt}, 0);

      // Clear coinciding with a lock-loss increment: clear wins
      bus.pll_locked = 1'b0;
      tick();
      tick();
      bus.clr_stats = 1'b1;
      tick();
      bus.clr_stats = 1'b0;
      chk("clrwin_state", {30'd0, bus.state},         0);
      chk("clrwin_loss",  {28'd0, bus.lock_loss_cnt}, 0);
      chk("clrwin_to",    {28'd0, bus.timeout_cnt},   0);

      // Async reset in RUN with a nonzero counter
      bus.pll_locked = 1'b1;
      wait_for("ar_run1", S_SRSTN, 1, 60, n);
      bus.pll_locked = 1'b0;
      wait_for("ar_loss", S_SRSTN, 0, 10, n);
      chk("ar_loss1", {28'd0, bus.lock_loss_cnt}, 1);
      bus.pll_locked = 1'b1;
      wait_for("ar_run2", S_SRSTN, 1, 60, n);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_pll_rst",   {31'd0, bus.pll_rst},       1);
      chk("ar_sys_rst_n", {31'd0, bus.sys_rst_n},     0);
      chk("ar_state",     {30'd0, bus.state},         0);
      chk("ar_loss",      {28'd0, bus.lock_loss_cnt}, 0);
      chk("ar_to",        {28'd0, bus.timeout_cnt},   0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
